program_counter_stack: RTL and testbench

PROGRAM_COUNTER_STACK -- requirements
Module: program_counter_stack

---
 rtl/program_counter_stack.sv | 77 +++++++
 tb/tb_program_counter_stack.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/program_counter_stack.sv
// rtl/program_counter_stack.sv - program counter with inc/branch/jump and a LIFO return-address stack
module program_counter_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       resetBar,
  input  logic                       doJumpBar,
  input  logic                       doInc,
  input  logic                       doBranch,
  input  logic                       doCall,
  input  logic                       doRet,
  input  logic [WIDTH-1:0]           dbus,
  output logic [WIDTH-1:0]           pc,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       fault
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DW-1:0] FULL_LVL = DW'(DEPTH);

  // stack entries carry no reset: anything at or above depth is unreachable
  logic [WIDTH-1:0] stack [DEPTH];

  logic [WIDTH-1:0] pc_inc;
  logic [IW-1:0]    push_idx;
  logic [IW-1:0]    top_idx;
  logic             is_full;
  logic             is_empty;
  logic             push_ok;

  assign pc_inc   = pc + WIDTH'(1);
  assign push_idx = IW'(depth);
  assign top_idx  = IW'(depth - DW'(1));
  assign is_full  = (depth == FULL_LVL);
  assign is_empty = (depth == '0);
  // a call only pushes when no return outranks it and there is room
  assign push_ok  = doCall && !doRet && !is_full;

  // pc, depth and fault: one prioritised operation per edge, ret > call > jump > branch > inc
  always_ff @(posedge clk or negedge resetBar) begin
    if (!resetBar) begin
      pc    <= '0;
      depth <= '0;
      fault <= 1'b0;
    end else if (doRet) begin
      if (is_empty) begin
        fault <= 1'b1;
      end else begin
        pc    <= stack[top_idx];
        depth <= depth - DW'(1);
      end
    end else if (doCall) begin
      if (is_full) begin
        fault <= 1'b1;
      end else begin
        pc    <= dbus;
        depth <= depth + DW'(1);
      end
    end else if (!doJumpBar) begin
      pc <= dbus;
    end else if (doBranch) begin
      pc <= pc + dbus;
    end else if (doInc) begin
      pc <= pc_inc;
    end
  end

  // return-address write on an accepted call; the address after the call site is saved
  always_ff @(posedge clk) begin
    if (resetBar && push_ok) begin
      stack[push_idx] <= pc_inc;
    end
  end

endmodule

// File: tb/tb_program_counter_stack.sv
// tb/tb_program_counter_stack.sv - self-checking bench for program_counter_stack against a queue model
module tb_program_counter_stack;

  logic       clk;
  logic       resetBar;
  logic       doJumpBar;
  logic       doInc;
  logic       doBranch;
  logic       doCall;
  logic       doRet;
  logic [7:0] dbus;
  logic [7:0] pc;
  logic [2:0] depth;
  logic       fault;

  int total;
  int bad;

  logic [7:0] m_pc;
  logic       m_fault;
  logic [7:0] m_stack [$];

  program_counter_stack #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk),
    .resetBar(resetBar),
    .doJumpBar(doJumpBar),
    .doInc(doInc),
    .doBranch(doBranch),
    .doCall(doCall),
    .doRet(doRet),
    .dbus(dbus),
    .pc(pc),
    .depth(depth),
    .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".pc"}, pc, m_pc);
    check({tag, ".depth"}, depth, m_stack.size());
    check({tag, ".fault"}, fault, m_fault);
  endtask

  task automatic idle();
    doJumpBar = 1'b1;
    doInc     = 1'b0;
    doBranch  = 1'b0;
    doCall    = 1'b0;
    doRet     = 1'b0;
    dbus      = 8'h00;
  endtask

  // drive one cycle of strobes, advance the model by the specified rules, check after the edge
  task automatic do_op(input logic r, input logic c, input logic jb, input logic b,
                       input logic i, input logic [7:0] d, input string tag);
    doRet = r; doCall = c; doJumpBar = jb; doBranch = b; doInc = i; dbus = d;
    if (r) begin
      if (m_stack.size() > 0) m_pc = m_stack.pop_back();
      else m_fault = 1'b1;
    end else if (c) begin
      if (m_stack.size() < 4) begin
        m_stack.push_back(m_pc + 8'd1);
        m_pc = d;
      end else begin
        m_fault = 1'b1;
      end
    end else if (!jb) begin
      m_pc = d;
    end else if (b) begin
      m_pc = m_pc + d;
    end else if (i) begin
      m_pc = m_pc + 8'd1;
    end
    @(posedge clk);
    #1;
    idle();
    check_model(tag);
  endtask

  // pulse reset between edges and check outputs while it is still low
  task automatic async_reset(input string tag);
    resetBar = 1'b0;
    #1;
    m_pc = 8'h00;
    m_fault = 1'b0;
    m_stack.delete();
    check({tag, ".pc"}, pc, 8'h00);
    check({tag, ".depth"}, depth, 3'd0);
    check({tag, ".fault"}, fault, 1'b0);
    #1;
    resetBar = 1'b1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    idle();
    resetBar = 1'b0;
    m_pc = 8'h00;
    m_fault = 1'b0;
    m_stack.delete();
    doInc = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset.pc", pc, 8'h00);
    check("reset.depth", depth, 3'd0);
    check("reset.fault", fault, 1'b0);
    resetBar = 1'b1;
    idle();

    // full increment sweep with wrap
    for (int k = 0; k < 256; k++) do_op(0, 0, 1, 0, 1, 8'h00, "inc_sweep");
    check("inc_wrap.pc", pc, 8'h00);
    check("inc_wrap.fault", fault, 1'b0);

    // call and return
    do_op(0, 0, 0, 0, 1, 8'h10, "jump10");
    do_op(0, 1, 1, 0, 0, 8'h80, "call80");
    check("call80.pc_const", pc, 8'h80);
    check("call80.depth_const", depth, 3'd1);
    do_op(1, 0, 1, 0, 0, 8'h00, "ret11");
    check("ret11.pc_const", pc, 8'h11);
    check("ret11.depth_const", depth, 3'd0);

    // nested calls until overflow, then unwind
    do_op(0, 0, 0, 0, 0, 8'h00, "jump00");
    do_op(0, 1, 1, 0, 0, 8'h20, "call1");
    do_op(0, 1, 1, 0, 0, 8'h40, "call2");
    do_op(0, 1, 1, 0, 0, 8'h60, "call3");
    do_op(0, 1, 1, 0, 0, 8'h70, "call4");
    do_op(0, 1, 1, 0, 0, 8'hA5, "call5_full");
    check("full.pc_const", pc, 8'h70);
    check("full.depth_const", depth, 3'd4);
    check("full.fault_const", fault, 1'b1);
    do_op(1, 0, 1, 0, 0, 8'h00, "unwind1");
    check("unwind1.pc_const", pc, 8'h61);
    do_op(1, 0, 1, 0, 0, 8'h00, "unwind2");
    check("unwind2.pc_const", pc, 8'h41);
    do_op(1, 0, 1, 0, 0, 8'h00, "unwind3");
    check("unwind3.pc_const", pc, 8'h21);
    do_op(1, 0, 1, 0, 0, 8'h00, "unwind4");
    check("unwind4.pc_const", pc, 8'h01);
    check("unwind4.fault_sticky", fault, 1'b1);

    // relative branches wrapping both ways
    async_reset("rst_a");
    do_op(0, 0, 0, 0, 0, 8'h05, "jump05");
    do_op(0, 0, 1, 1, 0, 8'hFA, "branch_back");
    check("branch_back.pc_const", pc, 8'hFF);
    do_op(0, 0, 1, 1, 0, 8'h02, "branch_fwd");
    check("branch_fwd.pc_const", pc, 8'h01);

    // all strobes at once: return wins
    do_op(0, 1, 1, 0, 0, 8'h50, "call50");
    do_op(1, 1, 0, 1, 1, 8'h99, "all_ret");
    check("all_ret.pc_const", pc, 8'h02);
    check("all_ret.depth_const", depth, 3'd0);
    do_op(1, 1, 0, 1, 1, 8'h99, "all_empty");
    check("all_empty.pc_const", pc, 8'h02);
    check("all_empty.fault_const", fault, 1'b1);

    // reset mid-sequence discards pending returns
    async_reset("rst_b");
    do_op(0, 0, 0, 0, 0, 8'h10, "jumpb");
    do_op(0, 1, 1, 0, 0, 8'h20, "callb1");
    do_op(0, 1, 1, 0, 0, 8'h33, "callb2");
    check("pre_rst.depth_const", depth, 3'd2);
    async_reset("rst_mid");
    do_op(1, 0, 1, 0, 0, 8'h00, "ret_after_rst");
    check("ret_after_rst.fault_const", fault, 1'b1);
    check("ret_after_rst.pc_const", pc, 8'h00);

    // random operations against the model, with occasional async resets
    async_reset("rst_rand");
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 49) == 0) begin
        async_reset("rand_rst");
      end else begin
        do_op($urandom_range(0, 6) == 0, $urandom_range(0, 5) == 0,
              $urandom_range(0, 5) != 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 1) == 0, 8'($urandom), "rand");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
